flit_link_arbiter: RTL

Round-robin scheduler that shares one serial flit link among NREQ serializing packet queues (FIFO with parallel-in/serial-out output stage). Picks a non-empty queue, pulses its read enable to launch a packet, then steers that queue's flit stream onto the link for exactly FLITS cycles. Gates each packet on a downstream packet-credit counter. Sits between the per-port outbound queues and the network link.

---
 rtl/flit_link_arbiter_pkg.sv | 20 ++
 rtl/flit_link_arbiter_if.sv | 37 +++
 rtl/flit_link_arbiter_rr_arbiter.sv | 71 +++++++
 rtl/flit_link_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/flit_link_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// flit_arb_pkg
// Shared types and default parameters for the flit link arbiter slice.
//   arb_state_e   : link scheduler state (IDLE waiting for a launch, SEND
//                   streaming the body of a packet)
//   *_DEF         : default values for the arbiter and interface parameters
// -----------------------------------------------------------------------------
package flit_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF     = 4;
    localparam int OUTWIDTH_DEF = 8;
    localparam int FLITS_DEF    = 8;
    localparam int CREDITS_DEF  = 4;

endpackage : flit_arb_pkg

// File: rtl/flit_link_arbiter_if.sv
// -----------------------------------------------------------------------------
// flit_link_if
// Bundle between the per-port serializing queues, the arbiter and the link.
//   empty/q_flit/credit_return : queue status, queue flits, downstream credits
//   re                         : per-queue launch pulse (one-hot or zero)
//   flit_out/valid/head/tail   : link flit and qualifiers
//   grant_id/busy              : current link owner, packet in flight
// master = arbiter side, slave = queue/link environment side.
// -----------------------------------------------------------------------------
interface flit_link_if #(
    parameter int NREQ     = 4,
    parameter int OUTWIDTH = 8
);
    localparam int IDXW = $clog2(NREQ);

    logic [NREQ-1:0]               empty;
    logic [NREQ-1:0][OUTWIDTH-1:0] q_flit;
    logic [NREQ-1:0]               re;
    logic                          credit_return;
    logic [OUTWIDTH-1:0]           flit_out;
    logic                          flit_valid;
    logic                          flit_head;
    logic                          flit_tail;
    logic [IDXW-1:0]               grant_id;
    logic                          busy;

    modport master (
        input  empty, q_flit, credit_return,
        output re, flit_out, flit_valid, flit_head, flit_tail, grant_id, busy
    );

    modport slave (
        output empty, q_flit, credit_return,
        input  re, flit_out, flit_valid, flit_head, flit_tail, grant_id, busy
    );

endinterface : flit_link_if

// File: rtl/flit_link_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick among NREQ requesters. The search starts just after the
// last granted index and wraps; the pointer only moves on advance_i.
//   clock, reset : system clock, synchronous active-high reset
//   req_i        : request vector
//   advance_i    : grant was consumed, remember gnt_idx_o as last grant
//   gnt_o        : one-hot grant (zero when no request)
//   gnt_idx_o    : index of the grant
//   any_o        : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import flit_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic                    advance_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_idx_o,
    output logic                    any_o
);
    localparam int              IDXW     = $clog2(NREQ);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    logic [IDXW-1:0] last_q;
    logic [IDXW-1:0] last_d;
    logic [IDXW-1:0] cand_s;
    logic            found_s;

    // Walk the ring from last_q+1, keeping the first requester seen
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        cand_s    = last_q;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = (cand_s == IDX_LAST) ? '0 : cand_s + IDX_ONE;
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                gnt_idx_o      = cand_s;
                gnt_o[cand_s]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_o = |req_i;
    end

    // Pointer next-state: follow the grant only when it is actually used
    always_comb begin
        if (advance_i) begin
            last_d = gnt_idx_o;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset to the top index so requester 0 wins first
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= IDX_LAST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/flit_link_arbiter.sv
// -----------------------------------------------------------------------------
// flit_link_arbiter
// Shares one serial flit link among NREQ serializing packet queues. In IDLE a
// queue is picked round-robin and launched in the same cycle (head flit goes
// straight out); in SEND the owner's flit stream is steered onto the link
// until FLITS flits have been sent. Launches are gated on a downstream
// packet-credit counter.
//   clock, reset : system clock, synchronous active-high reset
//   lnk          : flit_link_if master (queue inputs, re, link outputs,
//                  grant_id, busy)
// -----------------------------------------------------------------------------
module flit_link_arbiter
    import flit_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int OUTWIDTH = OUTWIDTH_DEF,
    parameter int FLITS    = FLITS_DEF,
    parameter int CREDITS  = CREDITS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    flit_link_if.master lnk
);
    localparam int IDXW = $clog2(NREQ);
    localparam int BW   = $clog2(FLITS);
    localparam int CW   = $clog2(CREDITS + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(FLITS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);

    arb_state_e      state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IDXW-1:0] grant_q, grant_d;
    logic [CW-1:0]   credits_q, credits_d;

    logic [NREQ-1:0] gnt_s;
    logic [IDXW-1:0] gnt_idx_s;
    logic            any_s;
    logic            launch_s;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_i     (~lnk.empty),
        .advance_i (launch_s),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (any_s)
    );

    // A launch needs a free downstream buffer, a request and an idle link
    always_comb begin
        launch_s = (state_q == IDLE) && (credits_q != '0) && any_s && !reset;
    end

    // FSM next-state, beat/owner tracking and Mealy link outputs
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        grant_d        = grant_q;
        lnk.re         = '0;
        lnk.flit_out   = '0;
        lnk.flit_valid = 1'b0;
        lnk.flit_head  = 1'b0;
        lnk.flit_tail  = 1'b0;
        lnk.grant_id   = '0;
        lnk.busy       = 1'b0;
        // Outputs are forced quiet while reset is asserted, even mid-packet
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (launch_s) begin
                        lnk.re         = gnt_s;
                        lnk.flit_out   = lnk.q_flit[gnt_idx_s];
                        lnk.flit_valid = 1'b1;
                        lnk.flit_head  = 1'b1;
                        lnk.grant_id   = gnt_idx_s;
                        grant_d        = gnt_idx_s;
                        beat_d         = BEAT_ONE;
                        state_d        = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEND: begin
                    lnk.flit_out   = lnk.q_flit[grant_q];
                    lnk.flit_valid = 1'b1;
                    lnk.grant_id   = grant_q;
                    lnk.busy       = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        lnk.flit_tail = 1'b1;
                        beat_d        = '0;
                        state_d       = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // Credit counter: launch and return in one cycle cancel; returns saturate
    always_comb begin
        if (launch_s && lnk.credit_return) begin
            credits_d = credits_q;
        end else if (launch_s) begin
            credits_d = credits_q - CRED_ONE;
        end else if (lnk.credit_return && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CRED_ONE;
        end else begin
            credits_d = credits_q;
        end
    end

    // State, beat, owner and credit registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            grant_q   <= '0;
            credits_q <= CRED_MAX;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            grant_q   <= grant_d;
            credits_q <= credits_d;
        end
    end

endmodule : flit_link_arbiter
